// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants, opcode values and fetch FSM state type
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // J-type target: upper nibble of the delay-slot address, 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [INSTR_W-1:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bundle: imem request/response, redirect, decode handshake
interface instr_fetch_if;
  import mips_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [5:0]         id_opcode;
  logic [31:0]        id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - decode slot plus one-entry skid buffer with flush
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [31:0]        in_pc_plus4,
  output logic               fill_skid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc_plus4
);

  logic               slot_valid_q, slot_valid_d;
  logic [INSTR_W-1:0] slot_instr_q, slot_instr_d;
  logic [31:0]        slot_pc4_q, slot_pc4_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [31:0]        skid_pc4_q, skid_pc4_d;
  logic               pop;

  assign pop       = slot_valid_q && out_ready;
  assign fill_skid = in_valid && slot_valid_q && !out_ready;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    slot_pc4_d   = slot_pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    // Flush drops valid bits only; the data registers keep their last contents.
    if (flush) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (pop) begin
        if (skid_valid_q) begin
          slot_instr_d = skid_instr_q;
          slot_pc4_d   = skid_pc4_q;
          skid_valid_d = 1'b0;
        end else begin
          slot_valid_d = 1'b0;
        end
      end
      if (in_valid) begin
        if (fill_skid) begin
          skid_valid_d = 1'b1;
          skid_instr_d = in_instr;
          skid_pc4_d   = in_pc_plus4;
        end else begin
          slot_valid_d = 1'b1;
          slot_instr_d = in_instr;
          slot_pc4_d   = in_pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_instr_q <= '0;
      slot_pc4_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      slot_pc4_q   <= slot_pc4_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign out_valid    = slot_valid_q;
  assign out_instr    = slot_instr_q;
  assign out_pc_plus4 = slot_pc4_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction fetch: PC, single-outstanding imem requests, redirect/kill
// Optional FETCH_JUMP_EN: resolve J instructions in fetch on response acceptance.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tag_q, tag_d;
  logic         kill_q, kill_d;
  logic         run_q, run_d;
  logic [31:0]  tag_plus4;
  logic         rsp_fire;
  logic         rsp_accept;
  logic         is_jump;
  logic         fill_skid;
  logic         req;
  logic         grant;

  assign tag_plus4  = tag_q + 32'd4;
  assign rsp_fire   = (state_q == WAIT) && bus.imem_rvalid;
  assign rsp_accept = rsp_fire && !kill_q && !bus.redirect;

`ifdef FETCH_JUMP_EN
  assign is_jump = rsp_accept && (bus.imem_rdata[31:26] == OP_J);
`else
  assign is_jump = 1'b0;
`endif

  // run_q holds the first request off until the cycle after reset release.
  always_comb begin
    req = 1'b0;
    case (state_q)
      ISSUE:   req = run_q;
      WAIT:    req = rsp_accept && !fill_skid && !is_jump;
      default: req = 1'b0;
    endcase
  end

  assign grant = req && bus.imem_gnt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    kill_d  = kill_q;
    run_d   = 1'b1;

    if (grant) begin
      tag_d = pc_q;
      pc_d  = pc_q + 32'd4;
    end

    case (state_q)
      ISSUE: begin
        if (grant) state_d = WAIT;
      end
      WAIT: begin
        if (rsp_fire) begin
          kill_d = 1'b0;
          if (grant)          state_d = WAIT;
          else if (fill_skid) state_d = HOLD;
          else                state_d = ISSUE;
        end
        if (is_jump) pc_d = jump_target(tag_plus4, bus.imem_rdata);
      end
      HOLD: begin
        if (bus.id_ready) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase

    // A request still in flight after a redirect must be drained and discarded.
    if (bus.redirect) begin
      pc_d = bus.redirect_pc & ~32'd3;
      if ((state_q == WAIT && !rsp_fire) || grant) begin
        state_d = WAIT;
        kill_d  = 1'b1;
      end else begin
        state_d = ISSUE;
        kill_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
      kill_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      kill_q  <= kill_d;
      run_q   <= run_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (bus.redirect),
    .in_valid     (rsp_accept),
    .in_instr     (bus.imem_rdata),
    .in_pc_plus4  (tag_plus4),
    .fill_skid    (fill_skid),
    .out_valid    (bus.id_valid),
    .out_ready    (bus.id_ready),
    .out_instr    (bus.id_instr),
    .out_pc_plus4 (bus.id_pc_plus4)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.id_opcode = bus.id_instr[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch with an in-order stream model
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc = 0;
  int          gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
  logic        redir_now = 1'b0, redir_on_rvalid = 1'b0, redir_fired = 1'b0;
  logic [31:0] redir_target = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] got_pcs[$];
  int          hs_count = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_instr, prev_pc4;
  logic        gnt_this = 1'b0;
  logic [31:0] gnt_addr = '0;
  logic        watch_armed = 1'b0, watch_pending = 1'b0, watch_done = 1'b0;
  logic [31:0] watch_addr = '0, watch_next = '0;
  logic        wrap_seen = 1'b0;
  logic [31:0] wrap_pc4 = '0;

  // Instruction memory contents: fixed words at 0x0 and 0x100, a pattern elsewhere (never J).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    if (a == 32'h0)   return 32'h8C01_0004;
    if (a == 32'h100) return 32'h0800_0010;
    case (a[3:2])
      2'd0:    op = 6'h23;
      2'd1:    op = 6'h2B;
      2'd2:    op = 6'h04;
      default: op = 6'h00;
    endcase
    return {op, a[27:2] ^ 26'h15A_5A5A};
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] p4;
    logic        jump;
    p4   = pc + 32'd4;
    jump = 1'b0;
`ifdef FETCH_JUMP_EN
    jump = (instr[31:26] == 6'h02);
`endif
    return jump ? {p4[31:28], instr[25:0], 2'b00} : p4;
  endfunction

  task automatic step();
    int          lat;
    logic [31:0] ew;
    bus.imem_gnt = ($urandom_range(99) < gnt_pct);
    bus.id_ready = ($urandom_range(99) < ready_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    if (redir_on_rvalid && bus.imem_rvalid) begin
      redir_now       = 1'b1;
      redir_on_rvalid = 1'b0;
      redir_fired     = 1'b1;
    end
    if (!redir_now && redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      redir_now = 1'b1;
      if ($urandom_range(9) == 0) redir_target = 32'hFFFF_FFF0;
      else                        redir_target = 32'($urandom_range(1023)) << 2;
    end
    bus.redirect    = redir_now;
    bus.redirect_pc = redir_target | 32'($urandom_range(3));
    #1;
    if (prev_hold) begin
      check_eq("hold_valid", bus.id_valid, 1);
      check_eq("hold_instr", bus.id_instr, prev_instr);
      check_eq("hold_pc4", bus.id_pc_plus4, prev_pc4);
    end
    gnt_this = bus.imem_req && bus.imem_gnt;
    if (gnt_this) begin
      gnt_addr = bus.imem_addr;
      check_eq("one_outstanding", pend.size() - (bus.imem_rvalid ? 1 : 0), 0);
      lat = $urandom_range(lat_max, lat_min);
      pend.push_back('{addr: bus.imem_addr, due: cyc + lat});
      if (watch_pending) begin
        watch_next    = bus.imem_addr;
        watch_pending = 1'b0;
        watch_done    = 1'b1;
      end else if (watch_armed && bus.imem_addr == watch_addr) begin
        watch_armed   = 1'b0;
        watch_pending = 1'b1;
      end
    end
    if (bus.imem_rvalid) void'(pend.pop_front());
    if (bus.id_valid && bus.id_ready) begin
      ew = mem_word(exp_pc);
      check_eq("hs_instr", bus.id_instr, ew);
      check_eq("hs_opcode", bus.id_opcode, ew[31:26]);
      check_eq("hs_pc4", bus.id_pc_plus4, exp_pc + 32'd4);
      if (exp_pc == 32'hFFFF_FFFC) begin
        wrap_seen = 1'b1;
        wrap_pc4  = bus.id_pc_plus4;
      end
      got_pcs.push_back(exp_pc);
      hs_count++;
      exp_pc = model_next(exp_pc, ew);
    end
    if (bus.redirect) exp_pc = redir_target;
    prev_hold  = bus.id_valid && !bus.id_ready && !bus.redirect;
    prev_instr = bus.id_instr;
    prev_pc4   = bus.id_pc_plus4;
    @(posedge clk);
    cyc++;
    #1;
    redir_now = 1'b0;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    #1;
    check_eq("rst_req", bus.imem_req, 0);
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_valid", bus.id_valid, 0);
    check_eq("rst_instr", bus.id_instr, 0);
    check_eq("rst_opcode", bus.id_opcode, 0);
    check_eq("rst_pc4", bus.id_pc_plus4, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend.delete();
    got_pcs.delete();
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    hs_count  = 0;
    #1;
    check_eq("req_cycle0", bus.imem_req, 0);
  endtask

  task automatic watch_phase(input logic [31:0] target, input logic [31:0] wa);
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
    repeat (3) step();
    watch_addr = wa; watch_armed = 1'b1; watch_pending = 1'b0; watch_done = 1'b0;
    wrap_seen = 1'b0;
    redir_target = target;
    redir_now    = 1'b1;
    step();
    repeat (12) step();
    check_eq("watch_done", watch_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   h0;
    logic found;
    rst_n = 1'b1;
    #2;

    // Reset release, first fetch latency and back-to-back throughput.
    do_reset();
    step();
    check_eq("req_rise", bus.imem_req, 1);
    check_eq("first_addr", bus.imem_addr, 32'h0);
    step();
    step();
    check_eq("first_valid", bus.id_valid, 1);
    check_eq("first_instr", bus.id_instr, 32'h8C01_0004);
    check_eq("first_opcode", bus.id_opcode, 6'h23);
    check_eq("first_pc4", bus.id_pc_plus4, 32'h4);
    h0 = hs_count;
    repeat (20) step();
    check_eq("throughput", hs_count - h0, 20);

    // Decode stall fills slot and skid, then drains in order.
    do_reset();
    ready_pct = 0;
    repeat (5) step();
    check_eq("hold_no_req", bus.imem_req, 0);
    check_eq("hold_slot_valid", bus.id_valid, 1);
    check_eq("hold_no_pending", pend.size(), 0);
    ready_pct = 100;
    repeat (10) step();
    check_eq("drain_count", got_pcs.size() >= 3, 1);
    if (got_pcs.size() >= 3) begin
      check_eq("drain_0", got_pcs[0], 32'h0);
      check_eq("drain_1", got_pcs[1], 32'h4);
      check_eq("drain_2", got_pcs[2], 32'h8);
    end

    // Redirect while the 0x10 request is outstanding.
    do_reset();
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (gnt_this && gnt_addr == 32'h10) found = 1'b1;
    end
    check_eq("found_0x10", found, 1);
    redir_target = 32'h40;
    redir_now    = 1'b1;
    step();
    check_eq("redir_addr", bus.imem_addr, 32'h40);
    check_eq("redir_flush", bus.id_valid, 0);
    for (int i = 0; i < 30 && !bus.id_valid; i++) begin
      check_eq("redir_wait_valid", bus.id_valid, 0);
      step();
    end
    check_eq("redir_first_pc4", bus.id_pc_plus4, 32'h44);
    check_eq("redir_first_instr", bus.id_instr, mem_word(32'h40));

    // Redirect in the same cycle as a response.
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (6) step();
    redir_target    = 32'h200;
    redir_fired     = 1'b0;
    redir_on_rvalid = 1'b1;
    for (int i = 0; i < 20 && !redir_fired; i++) step();
    check_eq("rv_redir_fired", redir_fired, 1);
    check_eq("rv_redir_drop", bus.id_valid, 0);
    for (int i = 0; i < 30 && !bus.id_valid; i++) step();
    check_eq("rv_redir_pc4", bus.id_pc_plus4, 32'h204);

    // PC wrap-around at the top of the address space.
    watch_phase(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    check_eq("wrap_seen", wrap_seen, 1);
    check_eq("wrap_pc4", wrap_pc4, 32'h0);
    check_eq("wrap_next_addr", watch_next, 32'h0);

    // J word at 0x100.
    watch_phase(32'h100, 32'h100);
`ifdef FETCH_JUMP_EN
    check_eq("j_next_addr", watch_next, 32'h40);
`else
    check_eq("j_next_addr", watch_next, 32'h104);
`endif

    // Randomized traffic with a mid-run reset.
    do_reset();
    gnt_pct = 60; ready_pct = 70; lat_min = 1; lat_max = 4; redir_pct = 3;
    repeat (1200) step();
    do_reset();
    pend.push_back('{addr: 32'h80, due: cyc});
    redir_pct = 0;
    step();
    check_eq("stale_ignored", bus.id_valid, 0);
    redir_pct = 3;
    repeat (1200) step();
    check_eq("random_progress", hs_count > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the MIPS core. It sits directly upstream of the main control decoder and holds the program counter. It issues one word-aligned request at a time to instruction memory and buffers the returned word in a one-entry skid buffer. It presents the word to decode through a valid/ready handshake; `id_opcode` drives the main decoder's opcode input. Taken branches from execute redirect it.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, always equal to PC.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response word valid; responses arrive in order, at earliest one cycle after the grant.
- `imem_rdata`  in  32  response word.
- `redirect`  in  1  taken branch or jump from execute.
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and treated as 0.
- `id_valid`  out  1  decode slot holds an instruction.
- `id_ready`  in  1  decode consumes the slot this cycle.
- `id_instr`  out  32  instruction word.
- `id_opcode`  out  6  `id_instr[31:26]`, feeds the main decoder.
- `id_pc_plus4`  out  32  address of the instruction plus 4.

## Operation
- At most one request is outstanding. The FSM has three states:
  - ISSUE: `imem_req`=1. On `imem_gnt`: tag the request with the PC, set PC<=PC+4, go to WAIT.
  - WAIT: `imem_req`=0, except as described under Timing. On `imem_rvalid`: write the word into the decode slot if the slot is empty or `id_ready`=1; otherwise write it into the skid buffer. Go to ISSUE, or to HOLD if the skid buffer became full.
  - HOLD: no requests. When `id_ready`=1, the skid entry moves into the decode slot; go to ISSUE.
- `id_pc_plus4` is the tag of the request plus 4, with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
- `redirect` has priority over every other event:
  - PC<=`redirect_pc`.
  - `id_valid` clears and the skid buffer clears.
  - The FSM goes to ISSUE. If a request is outstanding, or is granted in the same cycle, a kill flag is set instead and the FSM stays in WAIT.
  - A killed response is dropped without touching the slot or the skid buffer. The FSM then goes to ISSUE at the redirected PC.
- If `redirect` and `id_ready` are both asserted in the same cycle, the handshake completes and the slot is still cleared.
- If `redirect` and `imem_rvalid` are both asserted in the same cycle, the response is dropped.
- `id_instr` and `id_pc_plus4` hold their values while `id_valid`=1 and `id_ready`=0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_instr`=0, `id_opcode`=0, `id_pc_plus4`=0. Internal state: PC=`RESET_PC`, skid buffer empty, kill flag=0, FSM in ISSUE.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- Latency: `imem_rvalid` in cycle N gives `id_valid`=1 in cycle N+1.
- In WAIT, `imem_req` is asserted in the same cycle as `imem_rvalid` when the response is not killed, the skid buffer will stay empty, and `redirect`=0. A granted request in that cycle advances the PC and keeps the FSM in WAIT.
- Throughput: with a memory that grants immediately and responds one cycle later, and `id_ready` held at 1, one instruction per cycle.
- Reset asserted mid-operation returns all state to reset values immediately. A memory response arriving after reset is released is ignored, because no request is outstanding.

## Configuration
- `FETCH_JUMP_EN` defined:
  - Opcode 6'h02 (J) is decoded on `imem_rdata` when the response is accepted.
  - PC<={PC_tag+4[31:28], instr[25:0], 2'b00} is applied in the same cycle, replacing the PC+4 sequential path.
  - No request may be issued in that cycle.
  - The J word is still delivered to decode.
- `FETCH_JUMP_EN` undefined: J instructions are fetched sequentially; execute must redirect for them.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode constants `OP_RTYPE`=6'h00, `OP_LW`=6'h23, `OP_SW`=6'h2B, `OP_BEQ`=6'h04, `OP_J`=6'h02.
  - `fetch_state_t` (ISSUE, WAIT, HOLD).
  - Constant `INSTR_W`=32.
- One sub-module: `fetch_skid_buf`, which contains the decode slot plus the one-entry skid buffer with valid/ready and a flush input.

## Test plan
- Reset release, 1-cycle memory returning 32'h8C01_0004 at address 0, `id_ready`=1 -> `imem_req` rises at cycle 1; `id_instr`=32'h8C01_0004, `id_opcode`=6'h23, `id_pc_plus4`=4. Continued 1-cycle responses give one new `id_valid` per cycle.
- Decode stall: `id_ready`=0 for 4 cycles -> the slot and skid buffer fill, the FSM goes to HOLD, `imem_req`=0. Release `id_ready` -> instructions at 0x0, 0x4, 0x8 are delivered in order with none lost or duplicated.
- Redirect while a request is outstanding to 0x10: `redirect_pc`=0x40 -> the 0x10 response is dropped; the next `imem_addr` is 0x40; `id_valid` is 0 until the 0x40 word arrives.
- Same-cycle `redirect` and `imem_rvalid` -> the response is discarded and `id_valid` stays 0 next cycle.
- PC 32'hFFFF_FFFC fetched -> `id_pc_plus4`=0 and the next `imem_addr`=0.
- With `FETCH_JUMP_EN` defined, J word 32'h0800_0010 at 0x100 -> the next `imem_addr`=0x40. Without the macro, the next `imem_addr`=0x104.
